// File: rtl/ulpi_reg_arbiter_pkg.sv
// rtl/ulpi_reg_arbiter_pkg.sv - shared state encodings, ULPI register map and sizing helper
package ulpi_reg_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_GAP     = 3'd3,
    ST_RESPOND = 3'd4
  } arb_state_t;

  localparam logic [5:0] ULPI_FUN_CTRL = 6'h04;
  localparam logic [5:0] ULPI_OTG_CTRL = 6'h0A;
  localparam logic [5:0] ULPI_SCRATCH  = 6'h16;
  localparam int         REG_MAP_SIZE  = 6;

  // Counter width able to hold max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ulpi_rr_pick.sv
// rtl/ulpi_rr_pick.sv - combinational round-robin picker: first set request at or after ptr
module ulpi_rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   idx,
  output logic            valid
);

  int j;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    j      = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!valid && req[j]) begin
        valid     = 1'b1;
        idx       = PW'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ulpi_reg_arbiter.sv
// rtl/ulpi_reg_arbiter.sv - round-robin arbiter sharing the ULPI register port among NREQ requesters
module ulpi_reg_arbiter
  import ulpi_reg_arbiter_pkg::*;
#(
  parameter int NREQ        = 3,
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 255,
  parameter int RETRY_GAP   = 16
) (
  input  logic              CLK_60M,
  input  logic              RST_USB,
  input  logic [NREQ-1:0]   REQ_EN,
  input  logic [NREQ-1:0]   REQ_RW,
  input  logic [6*NREQ-1:0] REQ_ADDR,
  input  logic [8*NREQ-1:0] REQ_DATA_I,
  output logic [NREQ-1:0]   REQ_DONE,
  output logic [NREQ-1:0]   REQ_FAIL,
  output logic [7:0]        REQ_DATA_O,
  output logic [NREQ-1:0]   GRANT,
  output logic              BUSY,
  output logic [2:0]        ST,
  output logic              REG_EN,
  output logic              REG_RW,
  output logic [5:0]        REG_ADDR,
  output logic [7:0]        REG_DATA_I,
  input  logic [7:0]        REG_DATA_O,
  input  logic              REG_DONE,
  input  logic              REG_FAIL,
  input  logic              READY
);

  localparam int PW   = $clog2(NREQ);
  localparam int RW_W = cnt_width(MAX_RETRY);
  localparam int TW   = cnt_width(TIMEOUT_CYC);
  localparam int GW   = cnt_width(RETRY_GAP);

  localparam logic [RW_W-1:0] RETRY_MAX = RW_W'(MAX_RETRY);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYC);
  localparam logic [GW-1:0]   GAP_LAST  = GW'(RETRY_GAP - 1);
  localparam logic [PW-1:0]   PTR_LAST  = PW'(NREQ - 1);

  arb_state_t      state, next_state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   g_idx;
  logic [RW_W-1:0] retry_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [GW-1:0]   gap_cnt;

  logic [NREQ-1:0] pick_onehot;
  logic [PW-1:0]   pick_idx;
  logic            pick_valid;

  logic            resp_ok;
  logic            retry_inc;

  ulpi_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req    (REQ_EN),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    next_state = state;
    resp_ok    = 1'b0;
    retry_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (READY && pick_valid) next_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        next_state = READY ? ST_WAIT : ST_RESPOND;
      end
      ST_WAIT: begin
        // A completed transfer is reported as such even if FAIL or READY loss arrives with it.
        if (REG_DONE) begin
          next_state = ST_RESPOND;
          resp_ok    = 1'b1;
        end else if (!READY) begin
          next_state = ST_RESPOND;
        end else if (REG_FAIL || (tmo_cnt == TMO_LAST)) begin
          if (retry_cnt < RETRY_MAX) begin
            next_state = ST_GAP;
            retry_inc  = 1'b1;
          end else begin
            next_state = ST_RESPOND;
          end
        end
      end
      ST_GAP: begin
        if (!READY)                   next_state = ST_RESPOND;
        else if (gap_cnt == GAP_LAST) next_state = ST_ISSUE;
      end
      ST_RESPOND: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_60M) begin
    if (RST_USB) begin
      state      <= ST_IDLE;
      ST         <= 3'd0;
      BUSY       <= 1'b0;
      GRANT      <= '0;
      REQ_DONE   <= '0;
      REQ_FAIL   <= '0;
      REQ_DATA_O <= '0;
      REG_EN     <= 1'b0;
      REG_RW     <= 1'b0;
      REG_ADDR   <= '0;
      REG_DATA_I <= '0;
      rr_ptr     <= '0;
      g_idx      <= '0;
      retry_cnt  <= '0;
      tmo_cnt    <= '0;
      gap_cnt    <= '0;
    end else begin
      state    <= next_state;
      ST       <= next_state;
      BUSY     <= (next_state != ST_IDLE);
      REG_EN   <= (next_state == ST_ISSUE);
      REQ_DONE <= '0;
      REQ_FAIL <= '0;

      if ((next_state == ST_RESPOND) && (state != ST_RESPOND)) begin
        if (resp_ok) REQ_DONE <= GRANT;
        else         REQ_FAIL <= GRANT;
      end

      case (state)
        ST_IDLE: begin
          if (next_state == ST_ISSUE) begin
            GRANT      <= pick_onehot;
            g_idx      <= pick_idx;
            REG_RW     <= REQ_RW[pick_idx];
            REG_ADDR   <= REQ_ADDR[int'(pick_idx)*6 +: 6];
            REG_DATA_I <= REQ_DATA_I[int'(pick_idx)*8 +: 8];
            retry_cnt  <= '0;
          end
        end
        ST_ISSUE: begin
          tmo_cnt <= '0;
        end
        ST_WAIT: begin
          gap_cnt <= '0;
          if (tmo_cnt != TMO_LAST) tmo_cnt <= tmo_cnt + 1'b1;
          if (retry_inc)           retry_cnt <= retry_cnt + 1'b1;
          if (REG_DONE && !REG_RW) REQ_DATA_O <= REG_DATA_O;
        end
        ST_GAP: begin
          if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + 1'b1;
        end
        ST_RESPOND: begin
          GRANT      <= '0;
          rr_ptr     <= (g_idx == PTR_LAST) ? '0 : g_idx + 1'b1;
          REG_RW     <= 1'b0;
          REG_ADDR   <= '0;
          REG_DATA_I <= '0;
        end
        default: begin
          GRANT <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// tb/tb_ulpi_reg_arbiter.sv - directed scoreboard bench for ulpi_reg_arbiter with a simple PHY model
module tb_ulpi_reg_arbiter;
  import ulpi_reg_arbiter_pkg::*;

  localparam int NREQ = 3;
  localparam int GAP  = 16;
  localparam int TMO  = 255;

  logic              CLK_60M;
  logic              RST_USB;
  logic [NREQ-1:0]   REQ_EN;
  logic [NREQ-1:0]   REQ_RW;
  logic [6*NREQ-1:0] REQ_ADDR;
  logic [8*NREQ-1:0] REQ_DATA_I;
  logic [NREQ-1:0]   REQ_DONE;
  logic [NREQ-1:0]   REQ_FAIL;
  logic [7:0]        REQ_DATA_O;
  logic [NREQ-1:0]   GRANT;
  logic              BUSY;
  logic [2:0]        ST;
  logic              REG_EN;
  logic              REG_RW;
  logic [5:0]        REG_ADDR;
  logic [7:0]        REG_DATA_I;
  logic [7:0]        REG_DATA_O;
  logic              REG_DONE;
  logic              REG_FAIL;
  logic              READY;

  ulpi_reg_arbiter dut (
    .CLK_60M    (CLK_60M),
    .RST_USB    (RST_USB),
    .REQ_EN     (REQ_EN),
    .REQ_RW     (REQ_RW),
    .REQ_ADDR   (REQ_ADDR),
    .REQ_DATA_I (REQ_DATA_I),
    .REQ_DONE   (REQ_DONE),
    .REQ_FAIL   (REQ_FAIL),
    .REQ_DATA_O (REQ_DATA_O),
    .GRANT      (GRANT),
    .BUSY       (BUSY),
    .ST         (ST),
    .REG_EN     (REG_EN),
    .REG_RW     (REG_RW),
    .REG_ADDR   (REG_ADDR),
    .REG_DATA_I (REG_DATA_I),
    .REG_DATA_O (REG_DATA_O),
    .REG_DONE   (REG_DONE),
    .REG_FAIL   (REG_FAIL),
    .READY      (READY)
  );

  typedef struct packed {
    logic [NREQ-1:0] done;
    logic [NREQ-1:0] fail;
    logic            chk;
    logic [7:0]      data;
  } exp_t;

  exp_t sb[$];
  int   en_times[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;

  // PHY model knobs
  int       phy_lat        = 5;
  int       phy_fails_left = 0;
  bit       phy_silent     = 0;
  bit       phy_both       = 0;
  logic [7:0] phy_rdata    = 8'h00;
  logic [5:0] last_addr;
  logic [7:0] last_wdata;
  logic       last_rw;

  initial begin
    CLK_60M = 1'b0;
    forever #5 CLK_60M = ~CLK_60M;
  end

  initial forever begin
    @(posedge CLK_60M);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // PHY: answers each REG_EN pulse after phy_lat cycles unless silent.
  initial begin
    REG_DONE   = 1'b0;
    REG_FAIL   = 1'b0;
    REG_DATA_O = 8'h00;
    forever begin
      @(negedge CLK_60M);
      if (REG_EN === 1'b1) begin
        en_times.push_back(cyc);
        last_addr  = REG_ADDR;
        last_wdata = REG_DATA_I;
        last_rw    = REG_RW;
        if (!phy_silent) begin
          repeat (phy_lat - 1) @(negedge CLK_60M);
          REG_DATA_O = phy_rdata;
          if (phy_both) begin
            REG_DONE = 1'b1;
            REG_FAIL = 1'b1;
          end else if (phy_fails_left > 0) begin
            phy_fails_left--;
            REG_FAIL = 1'b1;
          end else begin
            REG_DONE = 1'b1;
          end
          @(negedge CLK_60M);
          REG_DONE = 1'b0;
          REG_FAIL = 1'b0;
        end
      end
    end
  end

  // Response monitor: every pulse must match the oldest scoreboard entry.
  initial forever begin
    exp_t e;
    @(negedge CLK_60M);
    if ((|REQ_DONE) || (|REQ_FAIL)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {REQ_DONE, REQ_FAIL}, 0);
      end else begin
        e = sb.pop_front();
        check("pulse_done", REQ_DONE, e.done);
        check("pulse_fail", REQ_FAIL, e.fail);
        check("grant_at_pulse", GRANT, e.done | e.fail);
        if (e.chk) check("read_data", REQ_DATA_O, e.data);
      end
    end
  end

  task automatic push_exp(input int i, input bit ok, input bit chk, input logic [7:0] d);
    exp_t e;
    e.done = ok ? NREQ'(1 << i) : '0;
    e.fail = ok ? '0 : NREQ'(1 << i);
    e.chk  = chk;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input bit rw, input logic [5:0] a, input logic [7:0] d);
    REQ_RW[i]          = rw;
    REQ_ADDR[6*i +: 6] = a;
    REQ_DATA_I[8*i +: 8] = d;
    REQ_EN[i]          = 1'b1;
  endtask

  task automatic wait_pulse(input int i, input int budget, output bit got);
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge CLK_60M);
      if (REQ_DONE[i] || REQ_FAIL[i]) got = 1'b1;
    end
  endtask

  task automatic wait_en(input int budget, output bit got);
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge CLK_60M);
      if (REG_EN) got = 1'b1;
    end
  endtask

  task automatic do_txn(input string tag, input int i, input bit rw, input logic [5:0] a,
                        input logic [7:0] d, input bit ok, input bit chk, input logic [7:0] rd,
                        input int budget);
    bit got;
    push_exp(i, ok, chk, rd);
    set_req(i, rw, a, d);
    wait_pulse(i, budget, got);
    check({tag, "_pulse_seen"}, got, 1);
    REQ_EN[i] = 1'b0;
    @(negedge CLK_60M);
    check({tag, "_grant_cleared"}, GRANT, 0);
    check({tag, "_pulse_single"}, {REQ_DONE, REQ_FAIL}, 0);
    check({tag, "_state_idle"}, ST, ST_IDLE);
  endtask

  initial begin
    bit got;
    int n;
    int d;

    RST_USB    = 1'b1;
    READY      = 1'b0;
    REQ_EN     = '0;
    REQ_RW     = '0;
    REQ_ADDR   = '0;
    REQ_DATA_I = '0;

    // Reset state
    repeat (3) @(posedge CLK_60M);
    @(negedge CLK_60M);
    check("rst_st", ST, ST_IDLE);
    check("rst_busy", BUSY, 0);
    check("rst_grant", GRANT, 0);
    check("rst_reg_en", REG_EN, 0);
    check("rst_pulses", {REQ_DONE, REQ_FAIL}, 0);
    check("rst_outputs", {REQ_DATA_O, REG_RW, REG_ADDR, REG_DATA_I}, 0);

    // READY low blocks every grant
    RST_USB = 1'b0;
    REQ_EN  = 3'b111;
    repeat (10) @(negedge CLK_60M);
    check("notready_grant", GRANT, 0);
    check("notready_busy", BUSY, 0);
    check("notready_en_count", en_times.size(), 0);
    REQ_EN = '0;
    READY  = 1'b1;
    @(negedge CLK_60M);

    // Single write on requester 1
    en_times.delete();
    phy_lat = 5;
    do_txn("write", 1, 1'b1, ULPI_SCRATCH, 8'h55, 1'b1, 1'b0, 8'h00, 100);
    check("write_en_count", en_times.size(), 1);
    check("write_addr", last_addr, ULPI_SCRATCH);
    check("write_data", last_wdata, 8'h55);
    check("write_rw", last_rw, 1);

    // Read on requester 0
    en_times.delete();
    phy_rdata = 8'h41;
    do_txn("read", 0, 1'b0, ULPI_FUN_CTRL, 8'hEE, 1'b1, 1'b1, 8'h41, 100);
    check("read_en_count", en_times.size(), 1);
    check("read_addr", last_addr, ULPI_FUN_CTRL);
    check("read_rw", last_rw, 0);
    phy_rdata = 8'h99;

    // Round robin: after requester 0 the pointer sits at 1
    en_times.delete();
    phy_lat = 2;
    for (int k = 0; k < 6; k++) push_exp((1 + k) % NREQ, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, ULPI_OTG_CTRL, 8'(8'h10 + i));
    n = 0;
    for (int k = 0; k < 400 && n < 6; k++) begin
      @(negedge CLK_60M);
      if (|REQ_DONE) n++;
    end
    REQ_EN = '0;
    check("rr_pulse_count", n, 6);
    check("rr_en_count", en_times.size(), 6);
    repeat (10) @(negedge CLK_60M);
    check("rr_idle_after", BUSY, 0);
    check("read_data_held", REQ_DATA_O, 8'h41);

    // Two FAILs then DONE: three issues, spaced by the retry gap
    en_times.delete();
    phy_lat = 3;
    phy_fails_left = 2;
    do_txn("retry_ok", 2, 1'b1, ULPI_OTG_CTRL, 8'hAA, 1'b1, 1'b0, 8'h00, 300);
    check("retry_ok_en_count", en_times.size(), 3);
    if (en_times.size() >= 3) begin
      d = en_times[1] - en_times[0];
      check("retry_gap_1", d >= GAP, 1);
      d = en_times[2] - en_times[1];
      check("retry_gap_2", d >= GAP, 1);
    end

    // FAIL every attempt: four issues then a failure pulse
    en_times.delete();
    phy_fails_left = 4;
    do_txn("retry_exhaust", 0, 1'b1, ULPI_SCRATCH, 8'h5A, 1'b0, 1'b0, 8'h00, 400);
    check("retry_exhaust_en_count", en_times.size(), 4);
    phy_fails_left = 0;

    // Silent PHY: watchdog drives the retries
    en_times.delete();
    phy_silent = 1'b1;
    do_txn("timeout", 1, 1'b0, ULPI_SCRATCH, 8'h00, 1'b0, 1'b0, 8'h00, 2500);
    check("timeout_en_count", en_times.size(), 4);
    if (en_times.size() >= 2) begin
      d = en_times[1] - en_times[0];
      check("timeout_spacing", d >= TMO, 1);
    end

    // READY drop in WAIT aborts with no retry
    en_times.delete();
    push_exp(2, 1'b0, 1'b0, 8'h00);
    set_req(2, 1'b1, ULPI_OTG_CTRL, 8'h01);
    wait_en(20, got);
    check("abort_issue_seen", got, 1);
    repeat (3) @(negedge CLK_60M);
    check("abort_in_wait", ST, ST_WAIT);
    READY = 1'b0;
    wait_pulse(2, 4, got);
    check("abort_pulse_seen", got, 1);
    REQ_EN[2] = 1'b0;
    repeat (2) @(negedge CLK_60M);
    READY = 1'b1;
    repeat (30) @(negedge CLK_60M);
    check("abort_no_retry", en_times.size(), 1);

    // DONE and FAIL in the same cycle resolve to DONE
    en_times.delete();
    phy_silent = 1'b0;
    phy_both   = 1'b1;
    phy_lat    = 4;
    do_txn("both", 0, 1'b1, ULPI_FUN_CTRL, 8'h33, 1'b1, 1'b0, 8'h00, 100);
    check("both_en_count", en_times.size(), 1);
    phy_both = 1'b0;

    // Reset in WAIT: back to IDLE, no pulse
    en_times.delete();
    phy_silent = 1'b1;
    set_req(1, 1'b1, ULPI_SCRATCH, 8'h77);
    wait_en(20, got);
    check("rstwait_issue_seen", got, 1);
    repeat (3) @(negedge CLK_60M);
    RST_USB = 1'b1;
    REQ_EN  = '0;
    @(negedge CLK_60M);
    check("rstwait_st", ST, ST_IDLE);
    check("rstwait_reg_en", REG_EN, 0);
    check("rstwait_grant", GRANT, 0);
    check("rstwait_busy", BUSY, 0);
    check("rstwait_pulses", {REQ_DONE, REQ_FAIL}, 0);
    RST_USB = 1'b0;
    repeat (20) @(negedge CLK_60M);
    check("rstwait_en_count", en_times.size(), 1);

    // Normal traffic resumes after reset
    phy_silent = 1'b0;
    phy_lat    = 5;
    phy_rdata  = 8'hC3;
    do_txn("post_rst_read", 2, 1'b0, ULPI_OTG_CTRL, 8'h00, 1'b1, 1'b1, 8'hC3, 100);

    repeat (5) @(negedge CLK_60M);
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
